// File: rtl/subtrator_serial_4b_if.sv
// Handshake/operand bundle for the bit-serial 4-bit subtractor.
// The ovf signal exists only when SUBTRATOR_OVERFLOW_EN is defined.
interface subtrator_serial_4b_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] d;
    logic       bout;
    logic       busy;
    logic       done;
`ifdef SUBTRATOR_OVERFLOW_EN
    logic       ovf;

    modport master (
        output start, a, b, bin,
        input  d, bout, busy, done, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output d, bout, busy, done, ovf
    );
`else
    modport master (
        output start, a, b, bin,
        input  d, bout, busy, done
    );

    modport slave (
        input  start, a, b, bin,
        output d, bout, busy, done
    );
`endif
endinterface

// File: rtl/subtrator_serial_4b.sv
// Bit-serial 4-bit subtractor d = a - b - bin, one bit per clock, LSB first.
// Define SUBTRATOR_OVERFLOW_EN to add the registered signed-overflow output ovf.
module subtrator_serial_4b (
    input  logic                  clk,
    input  logic                  rst_n,
    subtrator_serial_4b_if.slave  bus
);
    localparam int unsigned N_BITS = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state;
    logic [N_BITS-1:0] a_sr;
    logic [N_BITS-1:0] b_sr;
    logic [N_BITS-2:0] acc;
    logic [1:0]        count;
    logic              br;
    logic [N_BITS-1:0] d_q;
    logic              bout_q;
    logic              busy_q;
    logic              done_q;
`ifdef SUBTRATOR_OVERFLOW_EN
    logic              ovf_q;
`endif

    logic a_i;
    logic b_i;
    logic diff_i;
    logic br_next;

    // One full-subtractor cell; the current bit always sits at position 0 of the shifters.
    always_comb begin
        a_i     = a_sr[0];
        b_i     = b_sr[0];
        diff_i  = a_i ^ b_i ^ br;
        br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);
    end

    // NOTE: every register here is assigned with <= so all of them sample pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            acc    <= '0;
            count  <= '0;
            br     <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SUBTRATOR_OVERFLOW_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        br     <= bus.bin;
                        count  <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    br    <= br_next;
                    count <= count + 2'd1;
                    // Shifting in at the LSB leaves bit 0 at d[3] and bit 3 at d[0].
                    acc   <= {acc[N_BITS-3:0], diff_i};
                    if (count == 2'd3) begin
                        d_q    <= {acc, diff_i};
                        bout_q <= br_next;
`ifdef SUBTRATOR_OVERFLOW_EN
                        // br is the borrow into bit 3 on this final step.
                        ovf_q  <= br ^ br_next;
`endif
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.d    = d_q;
    assign bus.bout = bout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef SUBTRATOR_OVERFLOW_EN
    assign bus.ovf  = ovf_q;
`endif

    // Handshake invariants: done never overlaps busy and never lasts two cycles.
    a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n) !(done_q && busy_q));
    a_done_single:   assert property (@(posedge clk) disable iff (!rst_n) done_q |=> !done_q);

endmodule

// File: tb/tb_subtrator_serial_4b.sv
// Randomized self-checking bench for subtrator_serial_4b against an arithmetic reference model.
// Checks ovf as well when built with SUBTRATOR_OVERFLOW_EN.
module tb_subtrator_serial_4b;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    subtrator_serial_4b_if sif ();

    subtrator_serial_4b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] prev_d;
    logic       prev_bout;
    logic       prev_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain modulo-16 arithmetic, then the bit-reversed packing of d.
    function automatic logic [3:0] ref_d(input int a, input int b, input int bin);
        int         r;
        logic [3:0] v;
        r = (a - b - bin) & 15;
        v = r[3:0];
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic logic ref_bout(input int a, input int b, input int bin);
        return a < (b + bin);
    endfunction

    function automatic logic ref_ovf(input int a, input int b, input int bin);
        int sa;
        int sb;
        int s;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        s  = sa - sb - bin;
        return (s < -8) || (s > 7);
    endfunction

    function automatic logic get_ovf();
`ifdef SUBTRATOR_OVERFLOW_EN
        return sif.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge; mode 0 = quiet while busy, 1 = random noise, 2 = start with a=1,b=1.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bin, input int mode);
        int         lat;
        logic [3:0] exp_d;
        logic       exp_bout;
        logic       exp_ovf;
        exp_d    = ref_d(int'(a), int'(b), int'(bin));
        exp_bout = ref_bout(int'(a), int'(b), int'(bin));
        exp_ovf  = ref_ovf(int'(a), int'(b), int'(bin));
        sif.start = 1'b1;
        sif.a     = a;
        sif.b     = b;
        sif.bin   = bin;
        @(negedge clk);
        check("busy_on_accept", sif.busy, 1);
        check("done_low_on_accept", sif.done, 0);
        lat = 0;
        while (sif.done !== 1'b1 && lat < 8) begin
            check("d_hold", sif.d, prev_d);
            check("bout_hold", sif.bout, prev_bout);
            case (mode)
                1: begin
                    sif.start = 1'($urandom);
                    sif.a     = 4'($urandom);
                    sif.b     = 4'($urandom);
                    sif.bin   = 1'($urandom);
                end
                2: begin
                    sif.start = (lat < 3);
                    sif.a     = 4'd1;
                    sif.b     = 4'd1;
                end
                default: sif.start = 1'b0;
            endcase
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 4);
        check("busy_in_done", sif.busy, 0);
        check("d", sif.d, exp_d);
        check("bout", sif.bout, exp_bout);
`ifdef SUBTRATOR_OVERFLOW_EN
        check("ovf", sif.ovf, exp_ovf);
`endif
        prev_d    = exp_d;
        prev_bout = exp_bout;
        prev_ovf  = exp_ovf;
        sif.start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("idle_done", sif.done, 0);
            check("idle_busy", sif.busy, 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        sif.start = 1'b0;
        sif.a     = '0;
        sif.b     = '0;
        sif.bin   = 1'b0;
        prev_d    = '0;
        prev_bout = 1'b0;
        prev_ovf  = 1'b0;
        #12;
        check("rst_d", sif.d, 0);
        check("rst_bout", sif.bout, 0);
        check("rst_busy", sif.busy, 0);
        check("rst_done", sif.done, 0);
        check("rst_ovf", get_ovf(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);

        do_op(4'd7, 4'd3, 1'b0, 0);
        check("d_7m3_literal", sif.d, 4'b0010);
        idle_cycles(1);
        do_op(4'd3, 4'd5, 1'b0, 0);
        check("d_3m5_literal", sif.d, 4'b0111);
        check("bout_3m5_literal", sif.bout, 1);
        do_op(4'd0, 4'd0, 1'b1, 0);
        check("d_0m0m1_literal", sif.d, 4'b1111);
        do_op(4'd9, 4'd9, 1'b0, 0);
        check("d_9m9_literal", sif.d, 4'b0000);
        idle_cycles(2);
        do_op(4'd5, 4'd2, 1'b0, 2);
        check("d_5m2_literal", sif.d, 4'b1100);
        idle_cycles(3);

        // Reset in the middle of an operation aborts it.
        sif.start = 1'b1;
        sif.a     = 4'd8;
        sif.b     = 4'd1;
        sif.bin   = 1'b0;
        @(negedge clk);
        sif.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_d", sif.d, 0);
        check("midrst_bout", sif.bout, 0);
        check("midrst_busy", sif.busy, 0);
        check("midrst_done", sif.done, 0);
        check("midrst_ovf", get_ovf(), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        prev_d    = '0;
        prev_bout = 1'b0;
        prev_ovf  = 1'b0;
        idle_cycles(4);
        do_op(4'd8, 4'd1, 1'b0, 0);
        check("d_8m1_literal", sif.d, 4'b1110);
        check("bout_8m1_literal", sif.bout, 0);
`ifdef SUBTRATOR_OVERFLOW_EN
        check("ovf_8m1_literal", sif.ovf, 1);
`endif
        do_op(4'd6, 4'd2, 1'b0, 0);
`ifdef SUBTRATOR_OVERFLOW_EN
        check("ovf_6m2_literal", sif.ovf, 0);
`endif

        // Exhaustive sweep, issued back-to-back with random noise on the inputs while busy.
        for (int i = 0; i < 512; i++) begin
            do_op(i[3:0], i[7:4], i[8], 1);
        end
        idle_cycles(1);

        // Random operations with random idle gaps.
        for (int i = 0; i < 200; i++) begin
            do_op(4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/subtrator_serial_4b.md
Name: subtrator_serial_4b

Overview:
Bit-serial 4-bit subtractor computing d = a - b - bin. It processes one bit per clock, LSB first, using a single registered borrow flip-flop. This is the inverse-direction companion to the team's 4-bit ripple adder in the arithmetic datapath. It uses a start/busy/done handshake so a controller can issue one subtraction and collect the result and borrow-out.

Parameters:
- N_BITS, 4, operand width. Fixed at 4; the counter is 2 bits wide. Other values are unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  4  minuend, unsigned/two's complement, a[0] = LSB; sampled on the accepting edge.
- b  input  4  subtrahend, a[0]-style ordering (b[0] = LSB); sampled on the accepting edge.
- bin  input  1  borrow-in; sampled on the accepting edge.
- d  output  4  registered difference. Packed result order: d[3] = bit 0 (LSB) … d[0] = bit 3 (MSB).
- bout  output  1  registered borrow-out of bit 3.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when d/bout update.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, d=0, bout=0, busy=0, done=0, internal shift regs/count/borrow=0.
- States: IDLE, SHIFT.
- IDLE: start=1 at edge E0 does the following, then moves to SHIFT:
  - capture a, b into shift registers;
  - borrow_reg<=bin;
  - count<=0;
  - busy<=1.
  - start=0 keeps IDLE.
- SHIFT, bit i = count:
  - diff_i = a_i ^ b_i ^ br.
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - diff_i is written into the result accumulator at packed position d[3-i].
  - count increments.
- Bits 0..3 are processed at edges E1..E4. At E4:
  - d and bout are loaded from the accumulator/br_next together;
  - done<=1, busy<=0, state<=IDLE.
- Latency: done is high in the cycle after E4, i.e. 4 cycles after acceptance. Throughput is one operation per 5 cycles.
- A start that is high in the done cycle is accepted (back-to-back allowed).
- start while busy=1 is ignored, with no queuing. a/b/bin changes while busy have no effect.
- d/bout hold their previous result from acceptance until E4; they are not cleared on start.
- done lasts exactly one cycle and is never high while busy=1.
- Arithmetic is modulo 16. bout=1 iff a < b + bin (unsigned).
- Reset mid-operation aborts the operation: no done pulse, all outputs 0, next start behaves as from power-up.
- start held high continuously: a new operation is accepted every 5 cycles.

Optional Feature:
- Macro: SUBTRATOR_OVERFLOW_EN.
- Defined: adds output ovf (output, 1 bit, registered, reset 0).
  - ovf = borrow into bit 3 XOR borrow out of bit 3, i.e. signed two's-complement overflow.
  - Loaded at E4 alongside d/bout.
- Undefined: no ovf port and no extra logic.

Test Plan:
- a=7, b=3, bin=0, start pulse → 4 cycles later done=1; difference 4 (0100) gives d=4'b0010, bout=0; busy low in the done cycle.
- a=3, b=5, bin=0 → difference 14 (1110) gives d=4'b0111, bout=1.
- a=0, b=0, bin=1 → difference 15 gives d=4'b1111, bout=1. Next op a=9, b=9, bin=0 issued in the done cycle → accepted; d=4'b0000, bout=0 after 5 cycles.
- a=5, b=2, start; pulse start again with a=1, b=1 at cycles 1–3 → only one done, with d showing 3 (d=4'b1100). d holds the prior value until completion.
- rst_n low at cycle 2 of a=8, b=1 → outputs all 0 immediately, no done. A following op a=8, b=1 gives difference 7 (d=4'b1110), bout=0, and with SUBTRATOR_OVERFLOW_EN, ovf=1. a=6, b=2 gives ovf=0.
- Exhaustive: all 512 (a, b, bin) combos → d (unpacked) == (a-b-bin) mod 16, bout == (a < b+bin), exactly one done per accepted start.
